// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester/transmitter-side signal bundle for uart_tx_arbiter.
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0]   i_req;
  logic [NUM_REQ*8-1:0] i_req_byte;
  logic [NUM_REQ-1:0]   o_ack;
  logic                 o_tx_DV;
  logic [7:0]           o_tx_byte;
  logic                 i_tx_done;
  logic                 o_busy;
  logic [2:0]           o_grant_id;
  logic                 o_timeout;
  modport master (
    output i_req, i_req_byte, i_tx_done,
    input  o_ack, o_tx_DV, o_tx_byte, o_busy, o_grant_id, o_timeout
  );
  modport slave (
    input  i_req, i_req_byte, i_tx_done,
    output o_ack, o_tx_DV, o_tx_byte, o_busy, o_grant_id, o_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter, optional channel tag
// byte before each data byte, and a watchdog that drops a byte whose done never comes.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int TAG_EN       = 1,
  parameter int CLKS_PER_BIT = 87,
  parameter int TIMEOUT_CLKS = CLKS_PER_BIT * 12
) (
  input logic i_clk,
  input logic i_rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SEND_TAG  = 3'd1;
  localparam logic [2:0] WAIT_TAG  = 3'd2;
  localparam logic [2:0] SEND_DATA = 3'd3;
  localparam logic [2:0] WAIT_DATA = 3'd4;
  logic [2:0]         state_q, state_d, ptr_q, ptr_d, grant_q, grant_d;
  logic [7:0]         byte_q, byte_d, tx_byte_q, tx_byte_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d, rot;
  logic               dv_q, dv_d, busy_q, busy_d, to_q, to_d;
  logic [2:0]         off, win;
  // Rotate requests so bit 0 is the requester just after the pointer; lowest set bit wins.
  always_comb begin
    rot = NUM_REQ'({bus.i_req, bus.i_req} >> (ptr_q + 3'd1));
    off = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--)
      if (rot[j]) off = 3'(j);
    win = 3'((int'(ptr_q) + 1 + int'(off)) % NUM_REQ);
  end
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    byte_d    = byte_q;
    tx_byte_d = tx_byte_q;
    cnt_d     = cnt_q;
    ack_d     = '0;
    dv_d      = 1'b0;
    to_d      = 1'b0;
    case (state_q)
      IDLE: if (|bus.i_req) begin
        byte_d  = 8'(bus.i_req_byte >> {win, 3'b000});
        grant_d = win;
        ptr_d   = win;
        ack_d   = NUM_REQ'(1) << win;
        state_d = (TAG_EN != 0) ? SEND_TAG : SEND_DATA;
      end
      SEND_TAG, SEND_DATA: begin
        tx_byte_d = (state_q == SEND_TAG) ? (8'hA0 | {5'd0, grant_q}) : byte_q;
        dv_d      = 1'b1;
        cnt_d     = '0;
        state_d   = (state_q == SEND_TAG) ? WAIT_TAG : WAIT_DATA;
      end
      WAIT_TAG, WAIT_DATA: begin
        if (bus.i_tx_done) state_d = (state_q == WAIT_TAG) ? SEND_DATA : IDLE;
        else if (cnt_q == CW'(TIMEOUT_CLKS - 1)) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 3'(NUM_REQ - 1);
      grant_q   <= '0;
      byte_q    <= '0;
      tx_byte_q <= '0;
      cnt_q     <= '0;
      ack_q     <= '0;
      dv_q      <= 1'b0;
      busy_q    <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      byte_q    <= byte_d;
      tx_byte_q <= tx_byte_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      dv_q      <= dv_d;
      busy_q    <= busy_d;
      to_q      <= to_d;
    end
  end
  assign bus.o_ack      = ack_q;
  assign bus.o_tx_DV    = dv_q;
  assign bus.o_tx_byte  = tx_byte_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_grant_id = grant_q;
  assign bus.o_timeout  = to_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scenario tasks plus a scoreboard of expected grants and
// transmitted bytes, checked whenever the DUT pulses o_ack or o_tx_DV.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int CPB = 2;
  localparam int TO  = CPB * 12;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();
  uart_tx_arbiter #(.NUM_REQ(N), .TAG_EN(1), .CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
  );
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_tx[$];
  logic [2:0] exp_gnt[$];
  int done_dly = 9;
  logic mdl_done = 1'b0;
  logic tb_done = 1'b0;
  assign bus.i_tx_done = mdl_done | tb_done;
  // Transmitter model: done pulse sampled done_dly+1 edges after the DV edge; -1 = never.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.o_tx_DV && done_dly >= 0) begin
        for (int k = 0; k < done_dly && rst_n; k++) @(negedge clk);
        if (rst_n) begin
          mdl_done = 1'b1;
          @(negedge clk);
          mdl_done = 1'b0;
        end
      end
    end
  end
  logic [7:0] e_tx;
  logic [2:0] e_g;
  always @(negedge clk) begin
    if (bus.o_tx_DV) begin
      n_cmp++;
      if (exp_tx.size() == 0) begin
        n_bad++;
        $display("FAIL tx_byte: got %h, no byte expected", bus.o_tx_byte);
      end else begin
        e_tx = exp_tx.pop_front();
        if (bus.o_tx_byte !== e_tx) begin
          n_bad++;
          $display("FAIL tx_byte: got %h, expected %h", bus.o_tx_byte, e_tx);
        end
      end
    end
    if (bus.o_ack !== '0) begin
      n_cmp++;
      if (exp_gnt.size() == 0) begin
        n_bad++;
        $display("FAIL grant: got ack %b, no grant expected", bus.o_ack);
      end else begin
        e_g = exp_gnt.pop_front();
        if (bus.o_ack !== (N'(1) << e_g) || bus.o_grant_id !== e_g) begin
          n_bad++;
          $display("FAIL grant: got ack %b id %0d, expected id %0d", bus.o_ack, bus.o_grant_id, e_g);
        end
      end
    end
  end
  task automatic test_reset();
    bus.i_req = '0;
    bus.i_req_byte = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.o_ack, bus.o_tx_DV, bus.o_tx_byte, bus.o_busy, bus.o_grant_id, bus.o_timeout} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got ack %b dv %b byte %h busy %b id %0d to %b, expected all 0",
               bus.o_ack, bus.o_tx_DV, bus.o_tx_byte, bus.o_busy, bus.o_grant_id, bus.o_timeout);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_single();
    int k;
    exp_gnt.push_back(3'd2);
    exp_tx.push_back(8'hA2);
    exp_tx.push_back(8'h5C);
    bus.i_req_byte[23:16] = 8'h5C;
    bus.i_req = 4'b0100;
    k = 0;
    while (bus.o_ack === '0 && k < 10) begin @(negedge clk); k++; end
    n_cmp++;
    if (bus.o_ack !== 4'b0100) begin n_bad++; $display("FAIL single_ack: got %b, expected 0100", bus.o_ack); end
    bus.i_req = '0;
    @(negedge clk);
    n_cmp++;
    if (bus.o_ack !== 4'b0000) begin n_bad++; $display("FAIL single_ack_pulse: got %b, expected 0000", bus.o_ack); end
    for (int i = 0; i < 200 && bus.o_busy; i++) @(negedge clk);
    n_cmp++;
    if (bus.o_busy !== 1'b0 || exp_tx.size() != 0) begin
      n_bad++;
      $display("FAIL single_done: got busy %b pending %0d, expected busy 0 pending 0", bus.o_busy, exp_tx.size());
    end
  endtask
  task automatic test_round_robin();
    int acks;
    int k;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_req_byte = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int g = 0; g < 6; g++) begin
      exp_gnt.push_back(3'(g % 4));
      exp_tx.push_back(8'hA0 | 8'(g % 4));
      exp_tx.push_back(8'h10 + 8'(g % 4));
    end
    bus.i_req = 4'b1111;
    acks = 0;
    k = 0;
    while (acks < 6 && k < 600) begin
      @(negedge clk);
      k++;
      if (bus.o_ack !== '0) begin
        acks++;
        n_cmp++;
        if (bus.o_ack !== (N'(1) << bus.o_grant_id)) begin
          n_bad++;
          $display("FAIL rr_id_match: got ack %b id %0d", bus.o_ack, bus.o_grant_id);
        end
        if (acks == 6) bus.i_req = '0;
      end
    end
    n_cmp++;
    if (acks != 6) begin n_bad++; $display("FAIL rr_count: got %0d grants, expected 6", acks); end
    bus.i_req = '0;
    for (int i = 0; i < 200 && bus.o_busy; i++) @(negedge clk);
    n_cmp++;
    if (exp_tx.size() != 0 || exp_gnt.size() != 0) begin
      n_bad++;
      $display("FAIL rr_drain: got pending tx %0d grants %0d, expected 0", exp_tx.size(), exp_gnt.size());
    end
  endtask
  task automatic test_pointer_order();
    int k;
    exp_gnt.push_back(3'd3);
    exp_tx.push_back(8'hA3);
    exp_tx.push_back(8'hB3);
    exp_gnt.push_back(3'd1);
    exp_tx.push_back(8'hA1);
    exp_tx.push_back(8'hB1);
    bus.i_req_byte = {8'hB3, 8'h00, 8'hB1, 8'h00};
    bus.i_req = 4'b1010;
    k = 0;
    while (bus.i_req !== '0 && k < 300) begin
      @(negedge clk);
      k++;
      if (bus.o_ack[3]) bus.i_req[3] = 1'b0;
      if (bus.o_ack[1]) bus.i_req[1] = 1'b0;
    end
    bus.i_req = '0;
    for (int i = 0; i < 200 && bus.o_busy; i++) @(negedge clk);
    n_cmp++;
    if (exp_tx.size() != 0 || exp_gnt.size() != 0) begin
      n_bad++;
      $display("FAIL ptr_drain: got pending tx %0d grants %0d, expected 0", exp_tx.size(), exp_gnt.size());
    end
  endtask
  task automatic test_timeout();
    int k;
    done_dly = -1;
    exp_gnt.push_back(3'd0);
    exp_tx.push_back(8'hA0);
    bus.i_req_byte[7:0] = 8'h77;
    bus.i_req = 4'b0001;
    k = 0;
    while (bus.o_ack === '0 && k < 10) begin @(negedge clk); k++; end
    bus.i_req = '0;
    k = 0;
    while (!bus.o_tx_DV && k < 10) begin @(negedge clk); k++; end
    k = 0;
    while (!bus.o_timeout && k < TO + 5) begin @(negedge clk); k++; end
    n_cmp++;
    if (k != TO) begin n_bad++; $display("FAIL timeout_latency: got %0d cycles, expected %0d", k, TO); end
    n_cmp++;
    if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL timeout_idle: got busy %b, expected 0", bus.o_busy); end
    @(negedge clk);
    n_cmp++;
    if (bus.o_timeout !== 1'b0 || bus.o_tx_DV !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_pulse: got to %b dv %b, expected 0 0", bus.o_timeout, bus.o_tx_DV);
    end
    done_dly = 9;
    exp_gnt.push_back(3'd2);
    exp_tx.push_back(8'hA2);
    exp_tx.push_back(8'h3C);
    bus.i_req_byte[23:16] = 8'h3C;
    bus.i_req = 4'b0100;
    k = 0;
    while (bus.o_ack === '0 && k < 10) begin @(negedge clk); k++; end
    bus.i_req = '0;
    @(negedge clk);
    for (int i = 0; i < 200 && bus.o_busy; i++) @(negedge clk);
    n_cmp++;
    if (exp_tx.size() != 0 || bus.o_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_recover: got pending %0d busy %b, expected 0 0", exp_tx.size(), bus.o_busy);
    end
  endtask
  task automatic test_done_at_terminal();
    int k;
    logic saw_to;
    done_dly = TO - 1;
    exp_gnt.push_back(3'd1);
    exp_tx.push_back(8'hA1);
    exp_tx.push_back(8'h9E);
    bus.i_req_byte[15:8] = 8'h9E;
    bus.i_req = 4'b0010;
    k = 0;
    while (bus.o_ack === '0 && k < 10) begin @(negedge clk); k++; end
    bus.i_req = '0;
    saw_to = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 300 && bus.o_busy; i++) begin
      @(negedge clk);
      saw_to |= bus.o_timeout;
    end
    n_cmp++;
    if (saw_to !== 1'b0 || exp_tx.size() != 0) begin
      n_bad++;
      $display("FAIL done_terminal: got timeout %b pending %0d, expected 0 0", saw_to, exp_tx.size());
    end
    done_dly = 9;
    tb_done = 1'b1;
    @(negedge clk);
    tb_done = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.o_busy, bus.o_tx_DV, bus.o_ack, bus.o_timeout} !== '0) begin
      n_bad++;
      $display("FAIL idle_done: got busy %b dv %b ack %b to %b, expected 0", bus.o_busy, bus.o_tx_DV, bus.o_ack, bus.o_timeout);
    end
  endtask
  task automatic test_reset_mid();
    int k;
    int dvs;
    exp_gnt.push_back(3'd2);
    exp_tx.push_back(8'hA2);
    exp_tx.push_back(8'h44);
    bus.i_req_byte[23:16] = 8'h44;
    bus.i_req = 4'b0100;
    k = 0;
    while (bus.o_ack === '0 && k < 10) begin @(negedge clk); k++; end
    bus.i_req = '0;
    dvs = 0;
    k = 0;
    while (dvs < 2 && k < 100) begin
      @(negedge clk);
      k++;
      if (bus.o_tx_DV) dvs++;
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.o_ack, bus.o_tx_DV, bus.o_tx_byte, bus.o_busy, bus.o_grant_id, bus.o_timeout} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got ack %b dv %b byte %h busy %b id %0d to %b, expected all 0",
               bus.o_ack, bus.o_tx_DV, bus.o_tx_byte, bus.o_busy, bus.o_grant_id, bus.o_timeout);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_gnt.push_back(3'd0);
    exp_tx.push_back(8'hA0);
    exp_tx.push_back(8'h10);
    bus.i_req_byte = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.i_req = 4'b1111;
    k = 0;
    while (bus.o_ack === '0 && k < 10) begin @(negedge clk); k++; end
    n_cmp++;
    if (bus.o_ack !== 4'b0001) begin n_bad++; $display("FAIL post_reset_win: got %b, expected 0001", bus.o_ack); end
    bus.i_req = '0;
    @(negedge clk);
    for (int i = 0; i < 200 && bus.o_busy; i++) @(negedge clk);
    n_cmp++;
    if (exp_tx.size() != 0 || exp_gnt.size() != 0) begin
      n_bad++;
      $display("FAIL final_drain: got pending tx %0d grants %0d, expected 0", exp_tx.size(), exp_gnt.size());
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_pointer_order();
    test_timeout();
    test_done_at_terminal();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL sim_timeout: bench did not finish within time limit");
    $fatal(1);
  end
endmodule
